// File: rtl/ha_share_sched_pkg.sv
// rtl/ha_share_sched_pkg.sv - shared types, defaults and index helper for the HA share scheduler
package ha_share_sched_pkg;

  localparam int NREQ_DEF = 4;
  localparam int IDW_DEF  = 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  function automatic int wrap_idx(input int base, input int off, input int n);
    return (base + off) % n;
  endfunction

endpackage

// File: rtl/ha_share_sched_if.sv
// rtl/ha_share_sched_if.sv - requester/consumer bus of the HA share scheduler
interface ha_share_sched_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  logic            en;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] op_x;
  logic [NREQ-1:0] op_y;
  logic [NREQ-1:0] gnt;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [IDW-1:0]  rsp_id;
  logic            rsp_s;
  logic            rsp_c;
  logic            busy;

  modport master (
    output en, req, op_x, op_y, rsp_ready,
    input  gnt, rsp_valid, rsp_id, rsp_s, rsp_c, busy
  );

  modport slave (
    input  en, req, op_x, op_y, rsp_ready,
    output gnt, rsp_valid, rsp_id, rsp_s, rsp_c, busy
  );
endinterface

// File: rtl/ha_share_sched_ha.sv
// rtl/ha_share_sched_ha.sv - the single half-adder shared by all requesters
module half_adder (
  input  logic i_x,
  input  logic i_y,
  output logic o_s,
  output logic o_c
);
  assign o_s = i_x ^ i_y;
  assign o_c = i_x & i_y;
endmodule

// File: rtl/ha_share_sched_rr_pick.sv
// rtl/ha_share_sched_rr_pick.sv - combinational round-robin one-hot picker
module rr_pick
  import ha_share_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IDW-1:0]  i_ptr,
  output logic [NREQ-1:0] o_gnt,
  output logic [IDW-1:0]  o_idx
);
  logic           w_found;
  logic [IDW-1:0] w_j;

  // Search starts at the pointer so the most recent winner goes to the back of the line.
  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_j     = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_j = IDW'(wrap_idx(int'(i_ptr), k, NREQ));
      if (!w_found && i_req[w_j]) begin
        w_found    = 1'b1;
        o_gnt[w_j] = 1'b1;
        o_idx      = w_j;
      end
    end
  end
endmodule

// File: rtl/ha_share_sched.sv
// rtl/ha_share_sched.sv - round-robin time-sharing of one half-adder across NREQ requesters
module ha_share_sched
  import ha_share_sched_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int IDW  = IDW_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  ha_share_sched_if.slave bus
);
  state_t          r_state;
  state_t          w_state_nxt;
  logic [IDW-1:0]  r_ptr;
  logic            r_s1_v;
  logic [IDW-1:0]  r_s1_id;
  logic            r_s1_x;
  logic            r_s1_y;
  logic            r_rsp_valid;
  logic [IDW-1:0]  r_rsp_id;
  logic            r_rsp_s;
  logic            r_rsp_c;

  logic            w_stall;
  logic            w_grant_ok;
  logic [NREQ-1:0] w_req_gated;
  logic [NREQ-1:0] w_gnt;
  logic [IDW-1:0]  w_idx;
  logic            w_any;
  logic            w_ha_s;
  logic            w_ha_c;

  assign w_stall     = r_rsp_valid & ~bus.rsp_ready;
  assign w_req_gated = bus.req & {NREQ{w_grant_ok}};
  assign w_any       = |w_gnt;

  rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .i_req (w_req_gated),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx)
  );

  half_adder u_ha (
    .i_x (r_s1_x),
    .i_y (r_s1_y),
    .o_s (w_ha_s),
    .o_c (w_ha_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // DRAIN never grants, so only the pipeline contents decide when it may retire.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_ok  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.en) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        w_grant_ok = bus.en & ~w_stall;
        if (!bus.en) w_state_nxt = (r_s1_v || r_rsp_valid) ? S_DRAIN : S_IDLE;
      end
      S_DRAIN: begin
        if (!r_s1_v && (!r_rsp_valid || bus.rsp_ready) && !w_any) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (w_any) begin
      r_ptr <= IDW'(wrap_idx(int'(w_idx), 1, NREQ));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_v      <= 1'b0;
      r_s1_id     <= '0;
      r_s1_x      <= 1'b0;
      r_s1_y      <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_s     <= 1'b0;
      r_rsp_c     <= 1'b0;
    end else if (!w_stall) begin
      r_s1_v      <= w_any;
      r_s1_id     <= w_idx;
      r_s1_x      <= bus.op_x[w_idx];
      r_s1_y      <= bus.op_y[w_idx];
      r_rsp_valid <= r_s1_v;
      r_rsp_id    <= r_s1_id;
      r_rsp_s     <= w_ha_s;
      r_rsp_c     <= w_ha_c;
    end
  end

  assign bus.gnt       = w_gnt;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_id    = r_rsp_id;
  assign bus.rsp_s     = r_rsp_s;
  assign bus.rsp_c     = r_rsp_c;
  assign bus.busy      = (r_state != S_IDLE);
endmodule

// File: tb/tb_ha_share_sched.sv
// tb/tb_ha_share_sched.sv - directed self-checking bench for ha_share_sched
module tb_ha_share_sched;
  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  ha_share_sched_if #(.NREQ(4), .IDW(2)) bus ();

  ha_share_sched #(.NREQ(4), .IDW(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [3:0] OPX = 4'b0101;
  localparam logic [3:0] OPY = 4'b0011;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_rsp(input string tag, input int id);
    logic [3:0] vx;
    logic [3:0] vy;
    vx = OPX;
    vy = OPY;
    check({tag, "_valid"}, 32'(bus.rsp_valid), 32'd1);
    check({tag, "_id"}, 32'(bus.rsp_id), 32'(id));
    check({tag, "_s"}, 32'(bus.rsp_s), 32'(vx[id] ^ vy[id]));
    check({tag, "_c"}, 32'(bus.rsp_c), 32'(vx[id] & vy[id]));
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    bus.en        = 1'b0;
    bus.req       = 4'b0000;
    bus.rsp_ready = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    errors        = 0;
    checks        = 0;
    rst_n         = 1'b0;
    bus.en        = 1'b0;
    bus.req       = 4'b0000;
    bus.op_x      = 4'b0001;
    bus.op_y      = 4'b0001;
    bus.rsp_ready = 1'b1;
    tick();
    tick();
    check("rst_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_id", 32'(bus.rsp_id), 32'd0);
    check("rst_gnt", 32'(bus.gnt), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    rst_n = 1'b1;

    // 1) single request, latency two cycles
    bus.en  = 1'b1;
    bus.req = 4'b0001;
    #1;
    check("t1_idle_gnt", 32'(bus.gnt), 32'd0);
    tick();
    check("t1_gnt", 32'(bus.gnt), 32'b0001);
    check("t1_busy", 32'(bus.busy), 32'd1);
    tick();
    bus.req = 4'b0000;
    #1;
    check("t1_t1_valid", 32'(bus.rsp_valid), 32'd0);
    tick();
    check("t1_valid", 32'(bus.rsp_valid), 32'd1);
    check("t1_id", 32'(bus.rsp_id), 32'd0);
    check("t1_s", 32'(bus.rsp_s), 32'd0);
    check("t1_c", 32'(bus.rsp_c), 32'd1);
    tick();
    check("t1_done", 32'(bus.rsp_valid), 32'd0);

    // 2) all requesting: grants 0,1,2,3,0 back to back
    do_reset();
    bus.op_x = OPX;
    bus.op_y = OPY;
    bus.en   = 1'b1;
    bus.req  = 4'b1111;
    tick();
    for (int k = 0; k < 8; k++) begin
      if (k == 5) bus.req = 4'b0000;
      #1;
      check($sformatf("t2_gnt%0d", k), 32'(bus.gnt), (k < 5) ? (32'd1 << (k % 4)) : 32'd0);
      if (k >= 2 && k <= 6) check_rsp($sformatf("t2_rsp%0d", k), (k - 2) % 4);
      else check($sformatf("t2_nv%0d", k), 32'(bus.rsp_valid), 32'd0);
      tick();
    end

    // 3) pointer at 3 with req 1001, then wrap to 0
    bus.req = 4'b0100;
    #1;
    check("t3_gnt2", 32'(bus.gnt), 32'b0100);
    tick();
    bus.req = 4'b1001;
    #1;
    check("t3_gnt3", 32'(bus.gnt), 32'b1000);
    tick();
    bus.req = 4'b0001;
    #1;
    check("t3_gnt0", 32'(bus.gnt), 32'b0001);
    check_rsp("t3_rsp2", 2);
    tick();

    // 4) backpressure with two results in flight
    bus.req = 4'b0011;
    #1;
    check("t4_gnt1", 32'(bus.gnt), 32'b0010);
    check_rsp("t4_rsp3", 3);
    tick();
    bus.req = 4'b0001;
    #1;
    check("t4_gnt0", 32'(bus.gnt), 32'b0001);
    check_rsp("t4_rsp0a", 0);
    tick();
    bus.req       = 4'b0100;
    bus.rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("t4_stall_gnt%0d", k), 32'(bus.gnt), 32'd0);
      check_rsp($sformatf("t4_hold%0d", k), 1);
      tick();
    end
    bus.rsp_ready = 1'b1;
    #1;
    check("t4_rel_gnt", 32'(bus.gnt), 32'b0100);
    check_rsp("t4_rel_rsp1", 1);
    tick();
    bus.req = 4'b0000;
    #1;
    check_rsp("t4_rsp0", 0);
    tick();
    check_rsp("t4_rsp2", 2);
    tick();
    check("t4_empty", 32'(bus.rsp_valid), 32'd0);

    // 5) enable dropped with two in flight
    bus.req = 4'b1000;
    #1;
    check("t5_gnt3", 32'(bus.gnt), 32'b1000);
    tick();
    bus.req = 4'b0001;
    #1;
    check("t5_gnt0", 32'(bus.gnt), 32'b0001);
    tick();
    bus.en  = 1'b0;
    bus.req = 4'b0010;
    #1;
    check("t5_en_fall_gnt", 32'(bus.gnt), 32'd0);
    check_rsp("t5_rsp3", 3);
    tick();
    bus.en        = 1'b1;
    bus.rsp_ready = 1'b0;
    #1;
    check("t5_drain_gnt", 32'(bus.gnt), 32'd0);
    check("t5_drain_busy", 32'(bus.busy), 32'd1);
    check_rsp("t5_rsp0a", 0);
    tick();
    bus.rsp_ready = 1'b1;
    #1;
    check("t5_drain_busy2", 32'(bus.busy), 32'd1);
    check("t5_drain_gnt2", 32'(bus.gnt), 32'd0);
    check_rsp("t5_rsp0b", 0);
    tick();
    check("t5_idle_busy", 32'(bus.busy), 32'd0);
    check("t5_idle_valid", 32'(bus.rsp_valid), 32'd0);
    check("t5_idle_gnt", 32'(bus.gnt), 32'd0);
    tick();
    check("t5_rerun_gnt", 32'(bus.gnt), 32'b0010);

    // 6) asynchronous reset mid-stream
    tick();
    bus.req = 4'b0100;
    #1;
    check("t6_gnt2", 32'(bus.gnt), 32'b0100);
    tick();
    bus.req = 4'b0000;
    #1;
    check_rsp("t6_rsp1", 1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", 32'(bus.rsp_valid), 32'd0);
    check("t6_rst_id", 32'(bus.rsp_id), 32'd0);
    check("t6_rst_s", 32'(bus.rsp_s), 32'd0);
    check("t6_rst_c", 32'(bus.rsp_c), 32'd0);
    check("t6_rst_gnt", 32'(bus.gnt), 32'd0);
    check("t6_rst_busy", 32'(bus.busy), 32'd0);
    bus.req = 4'b0110;
    bus.en  = 1'b1;
    #2;
    rst_n = 1'b1;
    tick();
    check("t6_first_gnt", 32'(bus.gnt), 32'b0010);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
